// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front end. Owns the fetch PC and issues sequential word
// reads to a request/response memory port with variable latency. Up to
// MAX_OUTSTANDING reads may be in flight. Returned words are buffered in a
// DEPTH-entry FIFO and presented to decode through a valid/ready handshake.
// A redirect flushes the FIFO, reloads the PC and marks every read still in
// flight as stale so that its response is dropped on arrival.
//
// Parameters
//   ADDR_WIDTH       fetch address width
//   DATA_WIDTH       instruction word width
//   DEPTH            FIFO entries (power of two, >= 2)
//   MAX_OUTSTANDING  maximum issued-but-unreturned reads (>= 1)
//   RESET_PC         fetch PC loaded on reset
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   clk_en            global enable; all state holds while low
//   i_redirect        flush and restart fetch at i_redirect_pc (word aligned)
//   o_mem_req         read request valid
//   o_mem_addr        read address (the fetch PC register)
//   i_mem_ready       memory accepts the request this cycle
//   i_mem_rvalid      in-order read response valid
//   i_mem_rdata       read response data
//   o_instr_valid     FIFO holds at least one word
//   o_instr           head instruction word
//   o_instr_pc        PC of the head instruction
//   i_instr_ready     decode consumes the head this cycle
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned            ADDR_WIDTH      = 32,
    parameter int unsigned            DATA_WIDTH      = 32,
    parameter int unsigned            DEPTH           = 4,
    parameter int unsigned            MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC        = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_instr_valid,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_instr_pc,
    input  logic                  i_instr_ready
);

    // -------------------------------------------------------------------------
    // Widths
    // -------------------------------------------------------------------------
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    // Wide enough to hold fifo_count + outstanding and DEPTH + discard
    // without wrapping.
    localparam int unsigned SUM_W = CNT_W + OUT_W + 1;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] pc_q,          pc_d;          // next fetch address
    logic [ADDR_WIDTH-1:0] rsp_pc_q,      rsp_pc_d;      // PC of next live response
    logic [OUT_W-1:0]      outstanding_q, outstanding_d; // all reads in flight
    logic [OUT_W-1:0]      discard_q,     discard_d;     // stale reads in flight
    logic [CNT_W-1:0]      count_q,       count_d;
    logic [PTR_W-1:0]      wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,      rd_ptr_d;

    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc_q   [DEPTH];

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [SUM_W-1:0]      credits_used;
    logic [SUM_W-1:0]      credits_limit;
    logic                  below_max;
    logic                  has_credit;
    logic                  accept;
    logic                  stale_rsp;
    logic                  push;
    logic                  pop;
    logic                  unused_redirect_bits;

    assign redirect_pc          = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_bits = ^i_redirect_pc[1:0];

    // Each live read reserves a FIFO slot at issue time so a response can
    // always be pushed. Stale reads never push, so their reservation is
    // given back immediately by adding discard to the limit.
    assign credits_used  = SUM_W'(count_q) + SUM_W'(outstanding_q);
    assign credits_limit = SUM_W'(DEPTH) + SUM_W'(discard_q);
    assign below_max     = (outstanding_q < OUT_W'(MAX_OUTSTANDING));
    assign has_credit    = below_max && (credits_used < credits_limit);

    assign o_mem_req  = clk_en && !rst && !i_redirect && has_credit;
    assign o_mem_addr = pc_q;
    assign accept     = o_mem_req && i_mem_ready;

    // Responses arrive in order, so the first `discard_q` of them are the
    // stale ones belonging to the pre-redirect stream.
    assign stale_rsp = i_mem_rvalid && (discard_q != '0);
    assign push      = i_mem_rvalid && !stale_rsp && !i_redirect;
    assign pop       = o_instr_valid && i_instr_ready && !i_redirect;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + OUT_W'(accept) - OUT_W'(i_mem_rvalid);
        discard_d     = discard_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (i_redirect) begin
            // Redirect wins over push and pop. Every read still in flight
            // becomes stale, except one whose response lands this very cycle,
            // which is dropped here. No issue can happen this cycle.
            pc_d      = redirect_pc;
            rsp_pc_d  = redirect_pc;
            discard_d = outstanding_q - OUT_W'(i_mem_rvalid);
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end else begin
            if (accept) begin
                pc_d = pc_q + PC_STEP;
            end

            if (stale_rsp) begin
                discard_d = discard_q - OUT_W'(1);
            end

            if (push) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers sample their inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else if (clk_en) begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array is not reset; entries are only ever read while
    // count_q says they hold valid data, and the outputs are zeroed when the
    // FIFO is empty, so reset values would be unobservable.
    always_ff @(posedge clk) begin
        if (clk_en && !rst && push) begin
            fifo_data_q[wr_ptr_q] <= i_mem_rdata;
            fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    // -------------------------------------------------------------------------
    // Decode-side outputs
    // -------------------------------------------------------------------------
    // The head is read straight out of registered storage, so a pushed word
    // becomes visible the cycle after i_mem_rvalid and there is no
    // combinational path from the memory response to decode.
    assign o_instr_valid = (count_q != '0);
    assign o_instr       = o_instr_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign o_instr_pc    = o_instr_valid ? fifo_pc_q[rd_ptr_q]   : '0;

endmodule
